// File: rtl/alu_serial_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_control;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, ALU_control, src1, src2,
    input  result, zero, cout, overflow, busy, done
  );

  modport slave (
    input  start, ALU_control, src1, src2,
    output result, zero, cout, overflow, busy, done
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice evaluated LSB first, carry held in a register,
// result and flags assembled over WIDTH cycles behind a start/done handshake.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_serial_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100,
    OP_XOR = 4'b1101
  } alu_op_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_next;
  logic [3:0]       op_q;
  logic [IW-1:0]    i_q;
  logic             c_q, c_msb_q;
  logic             last, is_arith, inv_b, is_addsub;
  logic             b_eff, sum, carry_out, slice;
  logic             ovf_fix, slt_set;

  assign last      = (i_q == IW'(WIDTH-1));
  assign inv_b     = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_arith  = is_addsub || (op_q == OP_SLT);

  // Operands shift right each RUN cycle, so bit 0 is always the current bit i.
  always_comb begin
    b_eff     = b_q[0] ^ inv_b;
    sum       = a_q[0] ^ b_eff ^ c_q;
    carry_out = (a_q[0] & b_eff) | (c_q & (a_q[0] ^ b_eff));
    case (op_q)
      OP_AND:                 slice = a_q[0] & b_q[0];
      OP_OR:                  slice = a_q[0] | b_q[0];
      OP_ADD, OP_SUB, OP_SLT: slice = sum;
      OP_NOR:                 slice = ~(a_q[0] | b_q[0]);
      OP_XOR:                 slice = a_q[0] ^ b_q[0];
      default:                slice = 1'b0;
    endcase
    r_next = {slice, r_q[WIDTH-1:1]};
  end

  // In FIX, c_q already holds the carry out of the MSB.
  assign ovf_fix = c_msb_q ^ c_q;
  assign slt_set = r_q[WIDTH-1] ^ ovf_fix;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = (op_q == OP_SLT) ? FIX : DONE;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      op_q         <= '0;
      i_q          <= '0;
      c_q          <= 1'b0;
      c_msb_q      <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_d == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q  <= bus.src1;
            b_q  <= bus.src2;
            op_q <= bus.ALU_control;
            i_q  <= '0;
            c_q  <= (bus.ALU_control == OP_SUB) || (bus.ALU_control == OP_SLT);
          end
        end
        RUN: begin
          r_q <= r_next;
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          c_q <= carry_out;
          i_q <= i_q + 1'b1;
          if (last) begin
            c_msb_q <= c_q;
            // Non-SLT results are published on the edge into DONE so they are valid with done.
            if (op_q != OP_SLT) begin
              bus.result   <= r_next;
              bus.zero     <= (r_next == '0);
              bus.cout     <= is_addsub & carry_out;
              bus.overflow <= is_arith & (c_q ^ carry_out);
            end
          end
        end
        FIX: begin
          bus.result   <= {{(WIDTH-1){1'b0}}, slt_set};
          bus.zero     <= ~slt_set;
          bus.cout     <= 1'b0;
          bus.overflow <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for the bit-serial ALU sequencer with hand-computed expectations.
module tb_alu_serial_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_result;

  alu_serial_ctrl_if #(.WIDTH(32)) bus ();

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_z,
                        input logic exp_c, input logic exp_v,
                        input int exp_lat, input int pulse_at);
    int lat;
    int busy_cnt;
    bus.start       = 1'b1;
    bus.ALU_control = op;
    bus.src1        = a;
    bus.src2        = b;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.src1        = $urandom;
    bus.src2        = $urandom;
    bus.ALU_control = 4'($urandom);
    check({tag, "_hold"}, bus.result, last_result);
    lat      = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (lat == pulse_at) begin
        bus.start       = 1'b1;
        bus.ALU_control = 4'b0110;
        bus.src1        = 32'h0000_0001;
        bus.src2        = 32'h0000_0002;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy === 1'b1) busy_cnt++;
    check({tag, "_lat"},  32'(lat),       32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_cnt),  32'(exp_lat));
    check({tag, "_res"},  bus.result,     exp_res);
    check({tag, "_zero"}, 32'(bus.zero),  32'(exp_z));
    check({tag, "_cout"}, 32'(bus.cout),  32'(exp_c));
    check({tag, "_ovf"},  32'(bus.overflow), 32'(exp_v));
    last_result = exp_res;
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'b0, bus.busy, bus.done}, 32'h0);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    checks          = 0;
    errors          = 0;
    last_result     = '0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.ALU_control = 4'b0000;
    bus.src1        = '0;
    bus.src2        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {28'b0, bus.zero, bus.cout, bus.overflow, 1'b0}, 32'h0);
    check("rst_hs", {30'b0, bus.busy, bus.done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 33, 0);
    run_op("sub_eq",   4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 33, 0);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 33, 0);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 34, 0);
    run_op("slt_ovf",  4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 34, 0);
    run_op("and",      4'b0000, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op("or",       4'b0001, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op("nor",      4'b1100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op("xor",      4'b1101, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op("busy_st",  4'b0010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 33, 10);
    run_op("bad_op",   4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 33, 0);

    // Reset in RUN cycle 15, with start asserted during the reset cycle.
    bus.start       = 1'b1;
    bus.ALU_control = 4'b0010;
    bus.src1        = 32'h0000_0100;
    bus.src2        = 32'h0000_0200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    check("mid_rst_hs", {30'b0, bus.busy, bus.done}, 32'h0);
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_flags", {29'b0, bus.zero, bus.cout, bus.overflow}, 32'h0);
    last_result = '0;
    done_seen = 0;
    busy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'h0);
    check("mid_rst_no_busy", 32'(busy_seen), 32'h0);

    run_op("add_after_rst", 4'b0010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
